// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift/rotate execute stage: widths and op encodings.
package shift_exec_stage_pkg;

  localparam int DATA_W    = 16;
  localparam int AMT_W     = 4;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROR = 2'b10,
    OP_ILL = 2'b11
  } op_e;

endpackage

// File: rtl/shift_exec_stage_if.sv
// Decode-side request and writeback-side result handshake of the shift execute stage.
interface shift_exec_stage_if
  import shift_exec_stage_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_data, in_amt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_data, in_amt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/shift_exec_stage_shift_core.sv
// Combinational log shifter for SLL / SRA / ROR; illegal ops pass data through and flag err.
module shift_exec_stage_shift_core
  import shift_exec_stage_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  function automatic logic [DATA_W-1:0] shift_by(input op_e o,
                                                 input logic [DATA_W-1:0] x,
                                                 input int unsigned sh);
    logic signed [DATA_W-1:0] xs;
    logic [DATA_W-1:0]        r;
    xs = x;
    case (o)
      OP_SLL:  r = x << sh;
      OP_SRA:  r = xs >>> sh;
      OP_ROR:  r = (x >> sh) | (x << (DATA_W - sh));
      default: r = x;
    endcase
    return r;
  endfunction

  op_e               op_dec;
  logic [DATA_W-1:0] lvl [AMT_W+1];

  assign op_dec = op_e'(op);
  assign lvl[0] = data;

  // Level k conditionally applies a shift of 2**k, selected by amt[k].
  for (genvar k = 0; k < AMT_W; k++) begin : g_lvl
    assign lvl[k+1] = amt[k] ? shift_by(op_dec, lvl[k], 2**k) : lvl[k];
  end

  assign result = lvl[AMT_W];
  assign err    = (op_dec == OP_ILL);

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift/rotate execute stage with valid/ready on both sides and a retire-time Z flag.
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  shift_exec_stage_if.slave  bus,
  output logic               flag_z
);

  logic [1:0]        op_p1;
  logic [DATA_W-1:0] data_p1;
  logic [AMT_W-1:0]  amt_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic              vld_p1;

  logic [DATA_W-1:0] data_p2;
  logic [TAG_W-1:0]  tag_p2;
  logic              err_p2;
  logic              vld_p2;

  logic [DATA_W-1:0] res_p1;
  logic              err_p1;
  logic              adv_p1;
  logic              accept;
  logic              retire;

  assign adv_p1       = vld_p1 && (!vld_p2 || bus.out_ready);
  assign bus.in_ready = !flush && (!vld_p1 || adv_p1);
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = vld_p2 && bus.out_ready && !flush;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (flush)  vld_p1 <= 1'b0;
    else if (accept) vld_p1 <= 1'b1;
    else if (adv_p1) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1   <= bus.in_op;
      data_p1 <= bus.in_data;
      amt_p1  <= bus.in_amt;
      tag_p1  <= bus.in_tag;
    end
  end

  shift_exec_stage_shift_core u_core (
    .op     (op_p1),
    .data   (data_p1),
    .amt    (amt_p1),
    .result (res_p1),
    .err    (err_p1)
  );

  // Stage 2: result register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      tag_p2  <= '0;
      err_p2  <= 1'b0;
    end else begin
      if (flush)              vld_p2 <= 1'b0;
      else if (adv_p1)        vld_p2 <= 1'b1;
      else if (bus.out_ready) vld_p2 <= 1'b0;
      if (adv_p1 && !flush) begin
        data_p2 <= res_p1;
        tag_p2  <= tag_p1;
        err_p2  <= err_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         flag_z <= 1'b0;
    else if (retire) flag_z <= (data_p2 == '0);
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_tag   = tag_p2;
  assign bus.out_err   = err_p2;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed-vector bench for shift_exec_stage with hand-computed expected results.
module tb_shift_exec_stage;
  import shift_exec_stage_pkg::*;

  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flag_z;
  int   n_cmp = 0;
  int   n_err = 0;

  shift_exec_stage_if #(.TAG_W(TW)) bus ();

  shift_exec_stage #(.TAG_W(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bus    (bus),
    .flag_z (flag_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] a, input logic [TW-1:0] t);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_tag   = t;
  endtask

  // Single op through an idle pipe with out_ready=1; returns after it retires.
  task automatic run_one(input string name, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] a, input logic [TW-1:0] t, input logic [15:0] exp);
    bus.out_ready = 1'b1;
    drive(op, d, a, t);
    tick;
    bus.in_valid = 1'b0;
    chk({name, " early_vld"}, 32'(bus.out_valid), 0);
    tick;
    chk({name, " vld"},  32'(bus.out_valid), 1);
    chk({name, " data"}, 32'(bus.out_data), 32'(exp));
    chk({name, " tag"},  32'(bus.out_tag), 32'(t));
    chk({name, " err"},  32'(bus.out_err), (op == 2'b11) ? 1 : 0);
    tick;
  endtask

  logic [15:0] b2b_exp [8] = '{16'd1, 16'd4, 16'd12, 16'd32, 16'd80, 16'd192, 16'd448, 16'd1024};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 2'b00;
    bus.in_data = '0;
    bus.in_amt = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data",  32'(bus.out_data), 0);
    chk("rst out_tag",   32'(bus.out_tag), 0);
    chk("rst out_err",   32'(bus.out_err), 0);
    chk("rst flag_z",    32'(flag_z), 0);
    chk("rst in_ready",  32'(bus.in_ready), 1);

    run_one("ror8001_1", 2'b10, 16'h8001, 4'd1, 4'd1, 16'hC000);
    run_one("ror1234_4", 2'b10, 16'h1234, 4'd4, 4'd2, 16'h4123);
    run_one("ror1234_0", 2'b10, 16'h1234, 4'd0, 4'd3, 16'h1234);
    run_one("sra8000_15", 2'b01, 16'h8000, 4'd15, 4'd4, 16'hFFFF);
    chk("flagz nonzero", 32'(flag_z), 0);
    run_one("sll0001_15", 2'b00, 16'h0001, 4'd15, 4'd5, 16'h8000);
    run_one("sll00f0_4", 2'b00, 16'h00F0, 4'd4, 4'd6, 16'h0F00);
    run_one("sra8421_4", 2'b01, 16'h8421, 4'd4, 4'd7, 16'hF842);
    run_one("sra7fff_15", 2'b01, 16'h7FFF, 4'd15, 4'd8, 16'h0000);
    chk("flagz sra zero", 32'(flag_z), 1);

    // Back-to-back stream, one op per cycle
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        drive(2'b00, 16'(k + 1), 4'(k), TW'(k));
        #1;
        chk("b2b in_ready", 32'(bus.in_ready), 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      tick;
      if (k >= 1) begin
        chk("b2b vld",  32'(bus.out_valid), 1);
        chk("b2b data", 32'(bus.out_data), 32'(b2b_exp[k-1]));
        chk("b2b tag",  32'(bus.out_tag), 32'(k - 1));
      end
    end
    tick;
    chk("b2b drained", 32'(bus.out_valid), 0);

    // Downstream stall with a waiting op
    bus.out_ready = 1'b0;
    drive(2'b00, 16'h0003, 4'd1, 4'd1);
    tick;
    drive(2'b10, 16'h0001, 4'd1, 4'd2);
    tick;
    drive(2'b01, 16'hF000, 4'd4, 4'd3);
    #1;
    chk("stall in_ready", 32'(bus.in_ready), 0);
    for (int s = 0; s < 2; s++) begin
      tick;
      chk("stall vld",      32'(bus.out_valid), 1);
      chk("stall data",     32'(bus.out_data), 32'h0006);
      chk("stall tag",      32'(bus.out_tag), 1);
      chk("stall in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release in_ready", 32'(bus.in_ready), 1);
    tick;
    bus.in_valid = 1'b0;
    chk("release data B", 32'(bus.out_data), 32'h8000);
    chk("release tag B",  32'(bus.out_tag), 2);
    tick;
    chk("release data C", 32'(bus.out_data), 32'hFF00);
    chk("release tag C",  32'(bus.out_tag), 3);
    tick;
    chk("release drained", 32'(bus.out_valid), 0);
    chk("release flagz",   32'(flag_z), 0);

    // Flush with both stages full
    run_one("sll0000_3", 2'b00, 16'h0000, 4'd3, 4'd5, 16'h0000);
    chk("flagz before flush", 32'(flag_z), 1);
    bus.out_ready = 1'b0;
    drive(2'b00, 16'h0001, 4'd1, 4'd6);
    tick;
    drive(2'b00, 16'h0002, 4'd1, 4'd7);
    tick;
    chk("flush full vld", 32'(bus.out_valid), 1);
    drive(2'b10, 16'h00FF, 4'd4, 4'd8);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("flush in_ready", 32'(bus.in_ready), 0);
    tick;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush vld",    32'(bus.out_valid), 0);
    chk("flush flag_z", 32'(flag_z), 1);
    tick;
    chk("flush no ghost", 32'(bus.out_valid), 0);
    run_one("post_flush ror", 2'b10, 16'h00FF, 4'd4, 4'd9, 16'hF00F);
    chk("flagz post flush", 32'(flag_z), 0);

    // Illegal op
    run_one("ill0000", 2'b11, 16'h0000, 4'd5, 4'd10, 16'h0000);
    chk("ill flagz", 32'(flag_z), 1);
    run_one("illabcd", 2'b11, 16'hABCD, 4'd3, 4'd11, 16'hABCD);
    chk("ill flagz nz", 32'(flag_z), 0);
    run_one("ill0000b", 2'b11, 16'h0000, 4'd0, 4'd12, 16'h0000);

    // Reset with ops in flight
    bus.out_ready = 1'b0;
    drive(2'b00, 16'h0101, 4'd2, 4'd13);
    tick;
    drive(2'b10, 16'h1234, 4'd8, 4'd14);
    tick;
    chk("prerst vld", 32'(bus.out_valid), 1);
    rst = 1'b1;
    tick;
    chk("midrst vld",    32'(bus.out_valid), 0);
    chk("midrst data",   32'(bus.out_data), 0);
    chk("midrst tag",    32'(bus.out_tag), 0);
    chk("midrst err",    32'(bus.out_err), 0);
    chk("midrst flag_z", 32'(flag_z), 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("postrst in_ready", 32'(bus.in_ready), 1);
    tick;
    chk("postrst no ghost", 32'(bus.out_valid), 0);
    tick;
    chk("postrst no ghost2", 32'(bus.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
